softreg_responder: RTL and testbench

SOFTREG_RESPONDER -- requirements
Module: softreg_responder

---
 rtl/softreg_responder_pkg.sv | 28 ++
 rtl/softreg_responder.sv | 120 ++++++++++++
 tb/tb_softreg_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/softreg_responder_pkg.sv
// Shell-facing soft-register types and constants shared by the responder and its users.
package ShellTypes;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

    localparam logic [63:0] SOFTREG_ERR_DATA   = 64'hDEAD_DEAD_DEAD_DEAD;
    localparam int          SOFTREG_ADDR_SHIFT = 3;
    localparam int          SOFTREG_IDX_W      = 32 - SOFTREG_ADDR_SHIFT;

    // Byte address -> 64-bit word index relative to the block base; wraps modulo 2^32.
    function automatic logic [SOFTREG_IDX_W-1:0] softreg_idx(input logic [31:0] addr,
                                                             input logic [31:0] base);
        logic [31:0] diff;
        diff = addr - base;
        return diff[31:SOFTREG_ADDR_SHIFT];
    endfunction

endpackage

// File: rtl/softreg_responder.sv
// Two-stage soft-register responder: control bank, status word, cycle counter.
// Optional feature: define SOFTREG_ACCESS_CNT_EN to map an access-count register at idx NUM_REGS+2.
module softreg_responder
    import ShellTypes::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_REGS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  SoftRegReq                softreg_req,
    output SoftRegResp               softreg_resp,
    output logic [NUM_REGS*64-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse,
    input  logic [63:0]              status_in
);

    localparam int IDX_W = SOFTREG_IDX_W;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);
    localparam logic [IDX_W-1:0] CYCLE_IDX  = IDX_W'(NUM_REGS + 1);
`ifdef SOFTREG_ACCESS_CNT_EN
    localparam logic [IDX_W-1:0] ACC_IDX    = IDX_W'(NUM_REGS + 2);
`endif

    logic                         s1_vld_q;
    logic                         s1_wr_q;
    logic [IDX_W-1:0]             s1_idx_q;
    logic [63:0]                  s1_data_q;

    logic [NUM_REGS-1:0][63:0]    regs_q;
    logic [NUM_REGS-1:0]          pulse_q;
    SoftRegResp                   resp_q;
    logic [63:0]                  cycle_q;

    logic [63:0]                  rd_data_d;
    logic [NUM_REGS-1:0]          wr_hot_d;
    logic                         mapped_d;

`ifdef SOFTREG_ACCESS_CNT_EN
    logic [31:0]                  rd_cnt_q;
    logic [31:0]                  wr_cnt_q;
`endif

    // S2 decode: index compare per register keeps the select free of wide array indexing.
    always_comb begin
        rd_data_d = SOFTREG_ERR_DATA;
        wr_hot_d  = '0;
        mapped_d  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (s1_idx_q == IDX_W'(i)) begin
                rd_data_d   = regs_q[i];
                mapped_d    = 1'b1;
                wr_hot_d[i] = s1_vld_q & s1_wr_q;
            end
        end
        if (s1_idx_q == STATUS_IDX) begin
            rd_data_d = status_in;
            mapped_d  = 1'b1;
        end
        if (s1_idx_q == CYCLE_IDX) begin
            rd_data_d = cycle_q;
            mapped_d  = 1'b1;
        end
`ifdef SOFTREG_ACCESS_CNT_EN
        if (s1_idx_q == ACC_IDX) begin
            rd_data_d = {rd_cnt_q, wr_cnt_q};
            mapped_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_wr_q   <= 1'b0;
            s1_idx_q  <= '0;
            s1_data_q <= '0;
            regs_q    <= '0;
            pulse_q   <= '0;
            resp_q    <= '0;
            cycle_q   <= '0;
        end else begin
            s1_vld_q  <= softreg_req.valid;
            s1_wr_q   <= softreg_req.isWrite;
            s1_idx_q  <= softreg_idx(softreg_req.addr, BASE_ADDR);
            s1_data_q <= softreg_req.data;
            cycle_q   <= cycle_q + 64'd1;
            pulse_q   <= wr_hot_d;
            resp_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hot_d[i]) regs_q[i] <= s1_data_q;
            end
            if (s1_vld_q && !s1_wr_q) begin
                resp_q.valid <= 1'b1;
                resp_q.data  <= rd_data_d;
            end
        end
    end

`ifdef SOFTREG_ACCESS_CNT_EN
    // Saturating counters of mapped accesses, sampled as they leave S2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (s1_vld_q && mapped_d) begin
            if (s1_wr_q) begin
                if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end
`endif

    assign reg_out      = regs_q;
    assign reg_wr_pulse = pulse_q;
    assign softreg_resp = resp_q;

endmodule

// File: tb/tb_softreg_responder.sv
// Directed self-checking bench for softreg_responder (default NUM_REGS = 8, BASE_ADDR = 0).
module tb_softreg_responder;
    import ShellTypes::*;

    logic           clk = 1'b0;
    logic           rst_n;
    SoftRegReq      softreg_req;
    SoftRegResp     softreg_resp;
    logic [511:0]   reg_out;
    logic [7:0]     reg_wr_pulse;
    logic [63:0]    status_in;

    softreg_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .softreg_req  (softreg_req),
        .softreg_resp (softreg_resp),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse),
        .status_in    (status_in)
    );

    always #5 clk = ~clk;

    // Reference free-running counter: cleared while in reset, +1 per active edge otherwise.
    logic [63:0] cyc_m = '0;
    always @(posedge clk) cyc_m <= rst_n ? cyc_m + 64'd1 : 64'd0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic wr, input logic [31:0] addr, input logic [63:0] data);
        softreg_req = '{valid: 1'b1, isWrite: wr, addr: addr, data: data};
    endtask

    task automatic idle();
        softreg_req = '0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] data;
        logic [63:0] status;
        logic        rvld;
        logic [63:0] rdata;
        logic [7:0]  pulse;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [63:0] snap;
        int          idx;

        vecs[0]  = '{1'b1, 32'h10,        64'h1122_3344_5566_7788, 64'h0,    1'b0, 64'h0,                   8'h04};
        vecs[1]  = '{1'b0, 32'h10,        64'h0,                   64'h0,    1'b1, 64'h1122_3344_5566_7788, 8'h00};
        vecs[2]  = '{1'b0, 32'h17,        64'h0,                   64'h0,    1'b1, 64'h1122_3344_5566_7788, 8'h00};
        vecs[3]  = '{1'b1, 32'h38,        64'hFFFF_FFFF_FFFF_FFFF, 64'h0,    1'b0, 64'h0,                   8'h80};
        vecs[4]  = '{1'b0, 32'h38,        64'h0,                   64'h0,    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00};
        vecs[5]  = '{1'b0, 32'h40,        64'h0,                   64'h1234, 1'b1, 64'h1234,                8'h00};
        vecs[6]  = '{1'b1, 32'h40,        64'h5,                   64'h0,    1'b0, 64'h0,                   8'h00};
        vecs[7]  = '{1'b0, 32'h58,        64'h0,                   64'h0,    1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 8'h00};
        vecs[8]  = '{1'b1, 32'h60,        64'h1,                   64'h0,    1'b0, 64'h0,                   8'h00};
        vecs[9]  = '{1'b0, 32'hFFFF_FFF8, 64'h0,                   64'h0,    1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 8'h00};
        vecs[10] = '{1'b0, 32'h00,        64'h0,                   64'h0,    1'b1, 64'h0,                   8'h00};
        vecs[11] = '{1'b0, 32'h08,        64'h0,                   64'h0,    1'b1, 64'h0,                   8'h00};

        rst_n     = 1'b0;
        status_in = '0;
        idle();

        // Reset state, with a write presented during reset that must be ignored.
        @(negedge clk);
        drive(1'b1, 32'h0, 64'h77);
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp_vld", {63'h0, softreg_resp.valid}, 64'h0);
        chk("rst_resp_data", softreg_resp.data, 64'h0);
        chk("rst_pulse", {56'h0, reg_wr_pulse}, 64'h0);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_reg_out_zero", {63'h0, (reg_out != '0)}, 64'h0);

        // Table: one isolated transaction per entry.
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            status_in = vecs[v].status;
            drive(vecs[v].wr, vecs[v].addr, vecs[v].data);
            @(negedge clk);
            chk($sformatf("v%0d_t1_vld", v), {63'h0, softreg_resp.valid}, 64'h0);
            idle();
            @(negedge clk);
            chk($sformatf("v%0d_vld", v), {63'h0, softreg_resp.valid}, {63'h0, vecs[v].rvld});
            chk($sformatf("v%0d_data", v), softreg_resp.data, vecs[v].rdata);
            chk($sformatf("v%0d_pulse", v), {56'h0, reg_wr_pulse}, {56'h0, vecs[v].pulse});
            idx = int'(vecs[v].addr >> 3);
            if (vecs[v].wr && idx < 8)
                chk($sformatf("v%0d_reg_out", v), reg_out[idx*64 +: 64], vecs[v].data);
            @(negedge clk);
            chk($sformatf("v%0d_t3_vld", v), {63'h0, softreg_resp.valid}, 64'h0);
            chk($sformatf("v%0d_t3_pulse", v), {56'h0, reg_wr_pulse}, 64'h0);
        end

        // Write then immediate read of the same control register.
        @(negedge clk);
        drive(1'b1, 32'h18, 64'hA5);
        @(negedge clk);
        drive(1'b0, 32'h18, 64'h0);
        @(negedge clk);
        idle();
        chk("wr_rd_pulse", {56'h0, reg_wr_pulse}, 64'h08);
        chk("wr_rd_t2_vld", {63'h0, softreg_resp.valid}, 64'h0);
        @(negedge clk);
        chk("wr_rd_vld", {63'h0, softreg_resp.valid}, 64'h1);
        chk("wr_rd_data", softreg_resp.data, 64'hA5);

        // Four back-to-back reads: control 0, status, counter, unmapped.
        @(negedge clk);
        status_in = 64'hCAFE;
        drive(1'b0, 32'h00, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h40, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h48, 64'h0);
        chk("b2b0_vld", {63'h0, softreg_resp.valid}, 64'h1);
        chk("b2b0_data", softreg_resp.data, 64'h0);
        @(negedge clk);
        drive(1'b0, 32'h78, 64'h0);
        snap = cyc_m;
        chk("b2b1_vld", {63'h0, softreg_resp.valid}, 64'h1);
        chk("b2b1_data", softreg_resp.data, 64'hCAFE);
        @(negedge clk);
        idle();
        chk("b2b2_vld", {63'h0, softreg_resp.valid}, 64'h1);
        chk("b2b2_data", softreg_resp.data, snap);
        @(negedge clk);
        chk("b2b3_vld", {63'h0, softreg_resp.valid}, 64'h1);
        chk("b2b3_data", softreg_resp.data, 64'hDEAD_DEAD_DEAD_DEAD);
        @(negedge clk);
        chk("b2b_end_vld", {63'h0, softreg_resp.valid}, 64'h0);

        // Write to the counter index is dropped; the read still returns the counter.
        @(negedge clk);
        drive(1'b1, 32'h48, 64'h5);
        @(negedge clk);
        drive(1'b0, 32'h48, 64'h0);
        @(negedge clk);
        idle();
        snap = cyc_m;
        chk("ro_wr_pulse", {56'h0, reg_wr_pulse}, 64'h0);
        @(negedge clk);
        chk("ro_rd_vld", {63'h0, softreg_resp.valid}, 64'h1);
        chk("ro_rd_data", softreg_resp.data, snap);

        // Reset with a read in flight: no response may ever appear.
        @(negedge clk);
        drive(1'b0, 32'h10, 64'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("inflight_reg_out_zero", {63'h0, (reg_out != '0)}, 64'h0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("inflight_vld_c%0d", c), {63'h0, softreg_resp.valid}, 64'h0);
            @(negedge clk);
        end

        // Counter read issued in the first cycle after reset release sees 1 (0 then one edge).
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h48, 64'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("cnt_after_rst_vld", {63'h0, softreg_resp.valid}, 64'h1);
        chk("cnt_after_rst_data", softreg_resp.data, 64'h1);

`ifdef SOFTREG_ACCESS_CNT_EN
        // Access counts: 3 mapped reads, 2 mapped writes, 1 unmapped write.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            case (k)
                0: drive(1'b0, 32'h00, 64'h0);
                1: drive(1'b0, 32'h40, 64'h0);
                2: drive(1'b0, 32'h48, 64'h0);
                3: drive(1'b1, 32'h08, 64'h1);
                4: drive(1'b1, 32'h10, 64'h2);
                default: drive(1'b1, 32'hA0, 64'h3);
            endcase
            @(negedge clk);
            idle();
        end
        @(negedge clk);
        drive(1'b0, 32'h50, 64'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("acc_cnt_vld", {63'h0, softreg_resp.valid}, 64'h1);
        chk("acc_cnt_data", softreg_resp.data, 64'h0000_0003_0000_0002);
`else
        // Without the access counter, idx NUM_REGS+2 is unmapped.
        @(negedge clk);
        drive(1'b0, 32'h50, 64'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("idx10_vld", {63'h0, softreg_resp.valid}, 64'h1);
        chk("idx10_data", softreg_resp.data, 64'hDEAD_DEAD_DEAD_DEAD);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
